fsk_tdm_scheduler: RTL and testbench
====================================

Name: fsk_tdm_scheduler

Overview:
Time-division frame scheduler in front of the FSK modulator on the transmit side. It shares the single FSK bit-serial link among NCH PCM channels, each supplying 9-bit check-coded words. Each frame is a sync word followed by one fixed slot per channel. The block serializes the frame MSB-first at one bit per clock. It runs on the FSK bit clock (clk2 domain) and feeds the modulator bit input.

Parameters:
NCH, 4, number of requesting channels (2..8)
WORD_W, 9, bits per slot and per sync word (check-coded word width)
SYNC_WORD, 9'h1B5, pattern sent at frame start
IDLE_WORD, 9'h000, pattern sent in a slot whose channel had no word ready

Ports:
clk  input  1  FSK bit clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
enable  input  1  frame-generation enable
req  input  NCH  per-channel word-ready; held until ack
datain  input  NCH*WORD_W  channel i word at bits [i*WORD_W +: WORD_W]
ack  output  NCH  one-cycle registered pulse: channel word taken
txbit  output  1  serial bit to FSK modulator
txvalid  output  1  high while a frame bit is on txbit
frame_start  output  1  high during the first sync-bit cycle
slot_id  output  3  current slot index (0 during sync and idle)
busy  output  1  high in SYNC or SLOT state

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; shift register 0. Reset mid-frame aborts the frame immediately. No partial resume.
- States: IDLE, SYNC, SLOT. bitcnt runs 0..WORD_W-1. slotcnt runs 0..NCH-1.
- IDLE: enable sampled 1 on an edge -> SYNC next cycle, shift register loaded with SYNC_WORD, bitcnt=0. frame_start is high for that one cycle.
- Each cycle in SYNC or SLOT: txbit = shift register MSB, txvalid=1, busy=1. The register shifts left and bitcnt increments.
- Segment end (bitcnt=WORD_W-1): the next segment is loaded on the same edge.
  - SYNC -> SLOT 0.
  - SLOT k<NCH-1 -> SLOT k+1.
  - Last slot -> SYNC if enable=1, giving back-to-back frames with no gap. Otherwise -> IDLE.
- Slot load for channel i: req[i] is sampled on the loading edge.
  - If 1: shift register <= datain word i, and ack[i] is high for exactly the first bit-cycle of slot i.
  - If 0: shift register <= IDLE_WORD and ack stays 0.
  - A req rising after the loading edge waits for the next frame.
- At most one ack bit is high in any cycle. A requester may change data or drop req in the cycle ack is high.
- enable falling mid-frame has no effect until the frame ends. A complete frame is always sent.
- Frame length is (NCH+1)*WORD_W cycles (45 at defaults).
- In IDLE: txbit=0, txvalid=0, slot_id=0.
- Words pass through transparently; no parity is generated or checked here.

Decomposition:
- Package fsk_sched_pkg: state enumeration (IDLE/SYNC/SLOT), default WORD_W, SYNC_WORD and IDLE_WORD constants, slot-index width function.
- One sub-module, fsk_piso: WORD_W parallel-load/shift-left register with load and shift enables and MSB output.
- The scheduler FSM, counters and ack logic stay in the top module.

Test Plan:
(Defaults; cycle offsets relative to the frame_start cycle = 0.)
- Reset: reset=1 with enable=1 and req=4'hF -> all outputs 0 throughout, no ack. Reset release -> frame_start exactly 1 cycle after the first edge with enable=1.
- Single requester: req=4'b0001, word0=9'h155, enable held.
  - txbit offsets 0-8 = 1,1,0,1,1,0,1,0,1; offsets 9-17 = 1,0,1,0,1,0,1,0,1; offsets 18-44 all 0.
  - ack[0] high only at offset 9.
  - slot_id = 0,1,2,3 over offsets 9-17, 18-26, 27-35, 36-44.
- All requesters: words 9'h001, 9'h100, 9'h0F0, 9'h1FF, req=4'hF.
  - ack[0..3] pulse at offsets 9, 18, 27, 36.
  - Serial stream matches each word MSB-first in channel order.
  - Next frame_start at offset 45 with no gap.
- Enable drop: enable falls at offset 25 (slot 1) -> frame completes to offset 44; at offset 45 txvalid=0, busy=0, no frame_start.
- Late request: req[1] rises at offset 19 -> slot 1 carries 9'h000 with no ack. With enable held, ack[1] at offset 63 (45+18) and that word is sent in the next frame.
- Mid-frame reset: reset asserted at offset 32 (slot 2, bit 5) -> outputs 0 before the next edge. After release with enable=1, the new frame begins with the full SYNC_WORD; slot 2's earlier word is not resumed.

Source files
------------

// File: rtl/fsk_sched_pkg.sv
// Shared types and constants for the FSK TDM frame scheduler.
// Imported by the scheduler top and its serializer.
package fsk_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_SLOT = 2'd2
  } sched_state_t;

  localparam int          WORD_W_D    = 9;
  localparam logic [8:0]  SYNC_WORD_D = 9'h1B5;
  localparam logic [8:0]  IDLE_WORD_D = 9'h000;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fsk_piso.sv
// Parallel-load, shift-left register; MSB drives the serial link.
// Load has priority over shift; zeros enter at the LSB.
module fsk_piso
  import fsk_sched_pkg::*;
#(
  parameter int W = WORD_W_D
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  // Hold, load a new segment word, or shift one bit out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/fsk_tdm_scheduler.sv
// TDM frame scheduler: sync word then one slot per channel, MSB-first,
// one bit per FSK bit clock, with a one-cycle ack per word taken.
module fsk_tdm_scheduler
  import fsk_sched_pkg::*;
#(
  parameter int               NCH       = 4,
  parameter int               WORD_W    = WORD_W_D,
  parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_D,
  parameter logic [WORD_W-1:0] IDLE_WORD = IDLE_WORD_D
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NCH-1:0]        req,
  input  logic [NCH*WORD_W-1:0] datain,
  output logic [NCH-1:0]        ack,
  output logic                  txbit,
  output logic                  txvalid,
  output logic                  frame_start,
  output logic [2:0]            slot_id,
  output logic                  busy
);

  localparam int SW = idx_w(NCH);
  localparam int BW = idx_w(WORD_W);
  localparam logic [SW-1:0] SLAST = SW'(NCH - 1);
  localparam logic [BW-1:0] BLAST = BW'(WORD_W - 1);

  sched_state_t  state, state_n;
  logic [BW-1:0] bitcnt, bit_n;
  logic [SW-1:0] slotcnt, slot_n;
  logic [NCH-1:0] ack_q, ack_n;
  logic          load, shift, msb;
  logic [WORD_W-1:0] din;

  // State, counters and the registered ack pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bitcnt  <= '0;
      slotcnt <= '0;
      ack_q   <= '0;
    end else begin
      state   <= state_n;
      bitcnt  <= bit_n;
      slotcnt <= slot_n;
      ack_q   <= ack_n;
    end
  end

  // Segment sequencing; the next word is loaded on the segment's last edge.
  always_comb begin
    state_n = state;
    bit_n   = bitcnt;
    slot_n  = slotcnt;
    ack_n   = '0;
    load    = 1'b0;
    shift   = 1'b0;
    din     = IDLE_WORD;
    unique case (state)
      S_IDLE: begin
        bit_n  = '0;
        slot_n = '0;
        if (enable) begin
          state_n = S_SYNC;
          load    = 1'b1;
          din     = SYNC_WORD;
        end
      end
      S_SYNC, S_SLOT: begin
        if (bitcnt == BLAST) begin
          bit_n = '0;
          if (state == S_SYNC || slotcnt != SLAST) begin
            state_n = S_SLOT;
            slot_n  = (state == S_SYNC) ? '0 : slotcnt + 1'b1;
            load    = 1'b1;
            if (req[slot_n]) begin
              din           = datain[slot_n*WORD_W +: WORD_W];
              ack_n[slot_n] = 1'b1;
            end
          end else if (enable) begin
            state_n = S_SYNC;
            slot_n  = '0;
            load    = 1'b1;
            din     = SYNC_WORD;
          end else begin
            state_n = S_IDLE;
            slot_n  = '0;
          end
        end else begin
          bit_n = bitcnt + 1'b1;
          shift = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        bit_n   = '0;
        slot_n  = '0;
      end
    endcase
  end

  fsk_piso #(.W(WORD_W)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (din),
    .msb   (msb)
  );

  assign busy        = (state == S_SYNC) || (state == S_SLOT);
  assign txvalid     = busy;
  assign txbit       = busy & msb;
  assign frame_start = (state == S_SYNC) && (bitcnt == '0);
  assign slot_id     = (state == S_SLOT) ? 3'(slotcnt) : 3'd0;
  assign ack         = ack_q;

endmodule

// File: tb/tb_fsk_tdm_scheduler.sv
// Directed bench for fsk_tdm_scheduler at default parameters.
// Offsets are counted from the frame_start cycle (offset 0).
module tb_fsk_tdm_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  req;
  logic [35:0] datain;
  logic [3:0]  ack;
  logic        txbit, txvalid, frame_start, busy;
  logic [2:0]  slot_id;

  int passed = 0;
  int total  = 0;

  fsk_tdm_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req         (req),
    .datain      (datain),
    .ack         (ack),
    .txbit       (txbit),
    .txvalid     (txvalid),
    .frame_start (frame_start),
    .slot_id     (slot_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] rq;
    logic       tb;
    logic       tv;
    logic       fs;
    logic       bz;
    logic [2:0] sl;
    logic [3:0] ak;
  } vec_t;

  vec_t tbl [45];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      passed++;
  endtask

  function automatic logic [31:0] outs();
    return {20'd0, ack, txbit, txvalid, frame_start, busy, slot_id, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    req    = '0;
    datain = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  logic [17:0] pat;
  logic [44:0] got;
  logic [44:0] exp_stream;
  logic [8:0]  w;
  int          nack;

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    req    = 4'hF;
    datain = {9'h1FF, 9'h0F0, 9'h100, 9'h001};

    // Reset held with enable and all requests: everything quiet.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("reset_quiet%0d", i), outs(), 32'd0);
    end
    reset = 1'b0;
    chk("rel_no_fs", {31'd0, frame_start}, 32'd0);
    tick();
    chk("rel_fs", {30'd0, frame_start, txbit}, 32'd3);

    // Single requester frame from a table.
    pat = 18'b110110101_101010101;
    for (int o = 0; o < 45; o++) begin
      tbl[o].en = 1'b1;
      tbl[o].rq = 4'b0001;
      tbl[o].tb = (o < 18) ? pat[17-o] : 1'b0;
      tbl[o].tv = 1'b1;
      tbl[o].bz = 1'b1;
      tbl[o].fs = (o == 0);
      tbl[o].sl = (o < 9) ? 3'd0 : 3'((o - 9) / 9);
      tbl[o].ak = (o == 9) ? 4'b0001 : 4'b0000;
    end
    do_reset();
    datain = {27'd0, 9'h155};
    for (int o = 0; o < 45; o++) begin
      enable = tbl[o].en;
      req    = tbl[o].rq;
      tick();
      chk($sformatf("single_o%0d", o), outs(),
          {20'd0, tbl[o].ak, tbl[o].tb, tbl[o].tv, tbl[o].fs,
           tbl[o].bz, tbl[o].sl, 1'b0});
    end

    // All four requesters, back-to-back frame start.
    do_reset();
    datain     = {9'h1FF, 9'h0F0, 9'h100, 9'h001};
    req        = 4'hF;
    enable     = 1'b1;
    exp_stream = {9'h1B5, 9'h001, 9'h100, 9'h0F0, 9'h1FF};
    got        = '0;
    nack       = 0;
    for (int o = 0; o < 45; o++) begin
      tick();
      got = {got[43:0], txbit};
      if (o == 9 || o == 18 || o == 27 || o == 36)
        chk($sformatf("all_ack_o%0d", o), {28'd0, ack},
            32'(4'b0001 << ((o - 9) / 9)));
      else if (ack != 4'd0)
        nack++;
    end
    chk("all_stream_hi", {19'd0, got[44:32]}, {19'd0, exp_stream[44:32]});
    chk("all_stream_lo", got[31:0], exp_stream[31:0]);
    chk("all_stray_ack", nack, 0);
    tick();
    chk("all_next_fs", {29'd0, frame_start, txvalid, txbit}, 32'd7);

    // Enable drops in slot 1: frame completes, then idle.
    do_reset();
    enable = 1'b1;
    for (int o = 0; o < 45; o++) begin
      tick();
      if (o == 25) enable = 1'b0;
    end
    chk("drop_o44", {28'd0, txvalid, busy, slot_id[1:0]}, 32'hF);
    tick();
    chk("drop_o45", outs(), 32'd0);
    tick();
    chk("drop_o46", outs(), 32'd0);

    // Late request on channel 1 waits for the next frame.
    do_reset();
    enable = 1'b1;
    datain = {18'd0, 9'h0AB, 9'd0};
    got    = '0;
    nack   = 0;
    for (int o = 0; o < 72; o++) begin
      tick();
      if (o >= 18 && o <= 26) got = {got[43:0], txbit};
      if (o >= 63) got = {got[43:0], txbit};
      if (o < 63 && ack != 4'd0) nack++;
      if (o == 63) begin
        chk("late_ack63", {28'd0, ack}, 32'h2);
        req = 4'd0;
      end
      if (o == 19) req = 4'b0010;
    end
    chk("late_no_ack", nack, 0);
    chk("late_slot1_idle", {23'd0, got[17:9]}, 32'h000);
    chk("late_next_word", {23'd0, got[8:0]}, 32'h0AB);

    // Reset in slot 2 aborts; restart is a fresh full frame.
    do_reset();
    enable = 1'b1;
    req    = 4'hF;
    datain = {9'h1FF, 9'h0F0, 9'h100, 9'h001};
    for (int o = 0; o <= 32; o++) tick();
    chk("mid_slot2", {29'd0, slot_id}, 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_async", outs(), 32'd0);
    tick();
    chk("mid_hold", outs(), 32'd0);
    reset = 1'b0;
    w = '0;
    for (int o = 0; o < 10; o++) begin
      tick();
      if (o == 0) chk("mid_fs", {31'd0, frame_start}, 32'd1);
      if (o < 9) w = {w[7:0], txbit};
      if (o == 9)
        chk("mid_slot0", {25'd0, slot_id, ack}, {25'd0, 3'd0, 4'b0001});
    end
    chk("mid_sync", {23'd0, w}, 32'h1B5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
